// File: rtl/serial_pkg.sv
// Shared definitions for the serial adder datapath.
// Used by both the transmit and receive sides.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serial_state_e;

  function automatic int cnt_width(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/serial_tx_hold.sv
// One-word holding slot in front of the transmit shifter.
// Loads and takes never coincide: loads need it empty, takes need it full.
module serial_tx_hold
  import serial_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load_i,
  input  logic            take_i,
  input  logic [SIZE-1:0] data_i,
  output logic [SIZE-1:0] data_o,
  output logic            full_o
);

  logic [SIZE-1:0] data_q, data_d;
  logic            full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (take_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first.
// A holding slot keeps the serial stream gap-free across words.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = cnt_width(SIZE)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [SIZE-1:0] DATA_IN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic            BIT_OUT,
  output logic            BIT_VALID,
  output logic            BIT_FIRST,
  output logic            BIT_LAST,
  output logic            BUSY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  serial_state_e   state_q, state_d;
  logic [SIZE-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            hold_full;
  logic [SIZE-1:0] hold_data;
  logic            hold_load;
  logic            hold_take;

  logic accept;
  logic consume;
  logic finish;

  assign IN_READY = ~hold_full;
  assign accept   = IN_VALID & ~hold_full;
  assign consume  = BIT_VALID & EN;
  assign finish   = consume & (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    hold_load = 1'b0;
    hold_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_d    = DATA_IN;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (finish) begin
          cnt_d = '0;
          if (hold_full) begin
            sh_d      = hold_data;
            hold_take = 1'b1;
          end else if (accept) begin
            sh_d = DATA_IN;
          end else begin
            sh_d    = sh_q >> 1;
            state_d = ST_IDLE;
          end
        end else begin
          if (consume) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end
          hold_load = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_tx_hold #(
    .SIZE(SIZE)
  ) u_hold (
    .CLK   (CLK),
    .RST   (RST),
    .load_i(hold_load),
    .take_i(hold_take),
    .data_i(DATA_IN),
    .data_o(hold_data),
    .full_o(hold_full)
  );

  assign BIT_OUT   = sh_q[0];
  assign BIT_VALID = (state_q == ST_SHIFT);
  assign BIT_FIRST = BIT_VALID & (cnt_q == '0);
  assign BIT_LAST  = BIT_VALID & (cnt_q == CNT_LAST);
  assign BUSY      = BIT_VALID | hold_full;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: word-queue reference model plus directed cases.
// Includes a small SIZE=4 instance for the wrap boundary.
module tb_serial_word_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] DATA_IN = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY, BIT_OUT, BIT_VALID;
  logic       BIT_FIRST, BIT_LAST, BUSY;

  logic       en4 = 1'b0;
  logic [3:0] d4 = '0;
  logic       v4 = 1'b0;
  logic       r4, b4, bv4, bf4, bl4, busy4;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  int         pos = 0;

  always #5 CLK = ~CLK;

  serial_word_tx #(.SIZE(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .DATA_IN  (DATA_IN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .BIT_OUT  (BIT_OUT),
    .BIT_VALID(BIT_VALID),
    .BIT_FIRST(BIT_FIRST),
    .BIT_LAST (BIT_LAST),
    .BUSY     (BUSY)
  );

  serial_word_tx #(.SIZE(4)) dut4 (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (en4),
    .DATA_IN  (d4),
    .IN_VALID (v4),
    .IN_READY (r4),
    .BIT_OUT  (b4),
    .BIT_VALID(bv4),
    .BIT_FIRST(bf4),
    .BIT_LAST (bl4),
    .BUSY     (busy4)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic       v;
    logic [7:0] w;
    v = (mq.size() > 0);
    chk("valid", BIT_VALID, v);
    chk("busy", BUSY, v);
    chk("ready", IN_READY, mq.size() < 2);
    chk("first", BIT_FIRST, v && pos == 0);
    chk("last", BIT_LAST, v && pos == 7);
    if (v) begin
      w = mq[0];
      chk("bit", BIT_OUT, w[pos]);
    end
  endtask

  task automatic step();
    bit acc, con;
    @(negedge CLK);
    check_model();
    acc = IN_VALID && (mq.size() < 2);
    con = (mq.size() > 0) && EN;
    @(posedge CLK);
    if (con) begin
      pos++;
      if (pos == 8) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (acc) mq.push_back(DATA_IN);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_out"}, BIT_OUT, 1'b0);
    chk({tag, "_valid"}, BIT_VALID, 1'b0);
    chk({tag, "_first"}, BIT_FIRST, 1'b0);
    chk({tag, "_last"}, BIT_LAST, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_ready"}, IN_READY, 1'b1);
  endtask

  initial begin
    logic [7:0] pat4;

    // reset with a word offered: nothing may be taken
    IN_VALID = 1'b1;
    DATA_IN  = 8'hA5;
    EN       = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs("rst");
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    step();

    // single word
    IN_VALID = 1'b1;
    DATA_IN  = 8'hA5;
    step();
    IN_VALID = 1'b0;
    repeat (10) step();

    // back-to-back through the hold slot
    IN_VALID = 1'b1;
    DATA_IN  = 8'hA5;
    step();
    DATA_IN = 8'h3C;
    step();
    IN_VALID = 1'b0;
    repeat (17) step();

    // stall on bit 3
    IN_VALID = 1'b1;
    DATA_IN  = 8'h6B;
    step();
    IN_VALID = 1'b0;
    repeat (3) step();
    EN = 1'b0;
    repeat (3) step();
    EN = 1'b1;
    repeat (7) step();

    // reset mid-word with the hold slot full
    IN_VALID = 1'b1;
    DATA_IN  = 8'hFF;
    step();
    DATA_IN = 8'h01;
    step();
    IN_VALID = 1'b0;
    repeat (3) step();
    RST = 1'b0;
    #1;
    check_reset_outs("rstmid");
    mq.delete();
    pos = 0;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    check_reset_outs("rsthold");
    IN_VALID = 1'b0;
    RST = 1'b1;
    step();
    IN_VALID = 1'b1;
    DATA_IN  = 8'h80;
    step();
    IN_VALID = 1'b0;
    repeat (10) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      IN_VALID = ($urandom_range(0, 3) != 0);
      DATA_IN  = 8'($urandom);
      EN       = ($urandom_range(0, 4) != 0);
      step();
    end
    IN_VALID = 1'b0;
    EN = 1'b1;
    repeat (20) step();

    // SIZE=4: 1001 then 0110 contiguous
    pat4 = 8'b0110_1001;
    en4 = 1'b1;
    v4  = 1'b1;
    d4  = 4'b1001;
    @(posedge CLK);
    #1;
    d4 = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("s4_valid", bv4, 1'b1);
      chk("s4_bit", b4, pat4[i]);
      chk("s4_first", bf4, (i % 4) == 0);
      chk("s4_last", bl4, (i % 4) == 3);
      @(posedge CLK);
      #1;
      if (i == 0) v4 = 1'b0;
    end
    @(negedge CLK);
    chk("s4_done", bv4, 1'b0);
    chk("s4_busy", busy4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
